puf_resp_ctrl: RTL and testbench

- Measurement controller that sits directly downstream of the two RO counter banks and upstream of the pad outputs.
- Sweeps all challenges, gates the ring oscillators for a fixed window, and lets the counts settle.
- Compares the two 16-bit counts per challenge and packs one response bit per challenge into a 16-bit PUF response.
- Also drives the counter clear and the 4-bit mux select.

---
 rtl/puf_resp_ctrl.sv | 125 ++++++++++++
 tb/tb_puf_resp_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_resp_ctrl.sv
// RO-PUF measurement sequencer: sweeps 16 challenges, gates the oscillators for a
// fixed window, compares the two bank counts and packs one response bit per challenge.
module puf_resp_ctrl #(
  parameter int WINDOW = 256,
  parameter int SETTLE = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count_a,
  input  logic [CW-1:0] count_b,
  output logic          ro_en,
  output logic          cnt_clr,
  output logic [3:0]    challenge,
  output logic          busy,
  output logic [15:0]   resp,
  output logic          resp_valid,
  output logic [4:0]    tie_cnt
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, CLR_WAIT, RUN, STOP_WAIT, SAMPLE, DONE
  } state_t;

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
  localparam logic [7:0]  SET_LAST = 8'(SETTLE - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] win_cnt;
  logic [7:0]  settle_cnt;
  logic [15:0] work_resp;
  logic [4:0]  work_ties;
  logic        ro_en_d;
  logic        cnt_clr_d;
  logic        busy_d;

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = CLEAR;
      CLEAR:     next_state = CLR_WAIT;
      CLR_WAIT:  if (settle_cnt == SET_LAST) next_state = RUN;
      RUN:       if (win_cnt == WIN_LAST) next_state = STOP_WAIT;
      STOP_WAIT: if (settle_cnt == SET_LAST) next_state = SAMPLE;
      SAMPLE:    next_state = (challenge == 4'd15) ? DONE : CLEAR;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Decoded from next_state so the registered strobes line up with the state they belong to.
  always_comb begin
    ro_en_d   = (next_state == RUN);
    cnt_clr_d = (next_state == CLEAR);
    busy_d    = (next_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ro_en   <= 1'b0;
      cnt_clr <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ro_en   <= ro_en_d;
      cnt_clr <= cnt_clr_d;
      busy    <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      win_cnt    <= (state == RUN) ? win_cnt + 16'd1 : 16'd0;
      settle_cnt <= (state == CLR_WAIT || state == STOP_WAIT) ? settle_cnt + 8'd1 : 8'd0;
    end
  end

  // Challenge advances in SAMPLE, well before the next enable window opens.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      challenge  <= '0;
      work_resp  <= '0;
      work_ties  <= '0;
      resp       <= '0;
      tie_cnt    <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            challenge <= '0;
            work_resp <= '0;
            work_ties <= '0;
          end
        end
        SAMPLE: begin
          work_resp[challenge] <= (count_a > count_b);
          if (count_a == count_b && work_ties < 5'd16)
            work_ties <= work_ties + 5'd1;
          if (challenge != 4'd15)
            challenge <= challenge + 4'd1;
        end
        DONE: begin
          resp       <= work_resp;
          tie_cnt    <= work_ties;
          resp_valid <= 1'b1;
          challenge  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_ctrl.sv
// Bench for puf_resp_ctrl: behavioural RO bank model, expected-response scoreboard
// and a protocol monitor for enable/clear/challenge sequencing.
`timescale 1ns/1ps
module tb_puf_resp_ctrl;

  localparam int WINDOW   = 8;
  localparam int SETTLE   = 2;
  localparam int CW       = 16;
  localparam int PER_CHAL = 1 + SETTLE + WINDOW + SETTLE + 1;
  localparam int LATENCY  = 1 + 16 * PER_CHAL + 1;

  typedef struct {
    logic [15:0] resp;
    logic [4:0]  ties;
    int          t_start;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;
  logic          ro_en;
  logic          cnt_clr;
  logic [3:0]    challenge;
  logic          busy;
  logic [15:0]   resp;
  logic          resp_valid;
  logic [4:0]    tie_cnt;

  int   checks = 0;
  int   passed = 0;
  int   mode = 0;
  int   cyc = 0;
  exp_t sb[$];

  int          rv_count = 0, clr_count = 0, burst_count = 0;
  int          bad_burst = 0, bad_seq = 0, viol = 0;
  int          last_cyc = 0;
  logic [15:0] last_resp = '0;
  logic [4:0]  last_ties = '0;
  int          run_len = 0;
  logic        prev_ro = 1'b0;
  logic [3:0]  prev_chal = '0;
  logic [3:0]  next_chal = '0;

  int snap_rv, snap_clr, snap_burst, snap_badb, snap_bads, snap_viol, t_last;

  puf_resp_ctrl #(.WINDOW(WINDOW), .SETTLE(SETTLE), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_a(count_a), .count_b(count_b),
    .ro_en(ro_en), .cnt_clr(cnt_clr), .challenge(challenge), .busy(busy),
    .resp(resp), .resp_valid(resp_valid), .tie_cnt(tie_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RO bank model: counts depend only on the scenario and the selected challenge.
  function automatic logic [31:0] bank(input int m, input logic [3:0] k);
    case (m)
      0:       return {16'd100, 16'd50};
      1:       return k[0] ? {16'h8000, 16'h7FFF} : {16'h0001, 16'hFFFF};
      2:       return (k < 4'd4) ? {16'h1234, 16'h1234} : {16'd10, 16'd20};
      default: return {16'hFFFF, 16'hFFFF};
    endcase
  endfunction

  logic [31:0] bank_out;
  assign bank_out = bank(mode, challenge);
  assign count_a  = bank_out[31:16];
  assign count_b  = bank_out[15:0];

  function automatic exp_t predict(input int m, input int t);
    exp_t        e;
    logic [31:0] ab;
    e.resp = '0;
    e.ties = '0;
    e.t_start = t;
    for (int k = 0; k < 16; k++) begin
      ab = bank(m, 4'(k));
      if (ab[31:16] > ab[15:0]) e.resp[k] = 1'b1;
      else if (ab[31:16] == ab[15:0] && e.ties < 5'd16) e.ties = e.ties + 5'd1;
    end
    return e;
  endfunction

  // Protocol monitor; the tests read its counters as deltas.
  always @(negedge clk) begin
    if (rst_n) begin
      prev_ro   = 1'b0;
      run_len   = 0;
      next_chal = '0;
    end else begin
      if (ro_en && cnt_clr) viol++;
      if (ro_en && prev_ro && challenge != prev_chal) viol++;
      if (cnt_clr) clr_count++;
      if (ro_en && !prev_ro) begin
        burst_count++;
        if (challenge != next_chal) bad_seq++;
        next_chal = challenge + 4'd1;
        run_len = 1;
      end else if (ro_en) begin
        run_len++;
      end else if (prev_ro && run_len != WINDOW) begin
        bad_burst++;
      end
      if (resp_valid) begin
        rv_count++;
        last_cyc  = cyc;
        last_resp = resp;
        last_ties = tie_cnt;
      end
      prev_ro   = ro_en;
      prev_chal = challenge;
    end
  end

  task automatic do_start(input int m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    t_last = cyc;
    sb.push_back(predict(m, cyc));
    snap_rv = rv_count; snap_clr = clr_count; snap_burst = burst_count;
    snap_badb = bad_burst; snap_bads = bad_seq; snap_viol = viol;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int   n = 0;
    bit   got = 0;
    exp_t e;
    while (n < LATENCY + 20 && !got) begin
      @(negedge clk); #1;
      n++;
      if (rv_count != snap_rv) got = 1;
    end
    checks++;
    if (!got) $display("[TB] FAIL %s_done: no resp_valid within %0d cycles", name, LATENCY + 20);
    else passed++;
    if (got) begin
      checks++;
      if (sb.size() == 0) $display("[TB] FAIL %s_sb: resp_valid with empty scoreboard", name);
      else begin
        passed++;
        e = sb.pop_front();
        checks++;
        if (last_resp !== e.resp) $display("[TB] FAIL %s_resp: got %h expected %h", name, last_resp, e.resp);
        else passed++;
        checks++;
        if (last_ties !== e.ties) $display("[TB] FAIL %s_ties: got %0d expected %0d", name, last_ties, e.ties);
        else passed++;
        checks++;
        if (last_cyc - e.t_start != LATENCY)
          $display("[TB] FAIL %s_latency: got %0d expected %0d", name, last_cyc - e.t_start, LATENCY);
        else passed++;
      end
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (rv_count - snap_rv != 1) $display("[TB] FAIL %s_rv_pulses: got %0d expected 1", name, rv_count - snap_rv);
    else passed++;
    checks++;
    if (clr_count - snap_clr != 16) $display("[TB] FAIL %s_clr_pulses: got %0d expected 16", name, clr_count - snap_clr);
    else passed++;
    checks++;
    if (burst_count - snap_burst != 16) $display("[TB] FAIL %s_bursts: got %0d expected 16", name, burst_count - snap_burst);
    else passed++;
    checks++;
    if (bad_burst != snap_badb || bad_seq != snap_bads || viol != snap_viol)
      $display("[TB] FAIL %s_protocol: burst_len_err %0d chal_seq_err %0d overlap_err %0d expected 0 0 0",
               name, bad_burst - snap_badb, bad_seq - snap_bads, viol - snap_viol);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL %s_idle_busy: got %b expected 0", name, busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if ({ro_en, cnt_clr, busy, resp_valid} !== 4'b0000)
      $display("[TB] FAIL reset_ctrl: got ro_en/cnt_clr/busy/resp_valid=%b expected 0000", {ro_en, cnt_clr, busy, resp_valid});
    else passed++;
    checks++;
    if (resp !== 16'h0000 || tie_cnt !== 5'd0 || challenge !== 4'd0)
      $display("[TB] FAIL reset_data: got resp=%h tie=%0d chal=%0d expected 0000 0 0", resp, tie_cnt, challenge);
    else passed++;
    checks++;
    if (rv_count != 0) $display("[TB] FAIL reset_no_valid: got %0d pulses expected 0", rv_count);
    else passed++;
  endtask

  task automatic test_all_ones();
    do_start(0);
    wait_sweep("all_ones");
  endtask

  task automatic test_alternating();
    do_start(1);
    wait_sweep("alternating");
  endtask

  task automatic test_ties();
    do_start(2);
    wait_sweep("ties4");
    do_start(3);
    wait_sweep("ties16");
  endtask

  task automatic test_start_ignored();
    do_start(0);
    while (cyc < t_last + 50) @(negedge clk);
    start = 1'b1;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL ignore_mid_busy: got %b expected 1", busy);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t_last + 1 + 16 * PER_CHAL) @(negedge clk);
    start = 1'b1;
    checks++;
    if (busy !== 1'b1 || resp_valid !== 1'b0)
      $display("[TB] FAIL ignore_done_state: got busy=%b resp_valid=%b expected 1 0", busy, resp_valid);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    wait_sweep("ignored_starts");
    do_start(1);
    wait_sweep("after_ignore");
    do_start(0);
    wait_sweep("refill_ones");
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    int rv_base;
    do_start(1);
    rv_base = snap_rv;
    while (n < LATENCY && !(challenge == 4'd7 && ro_en)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(challenge == 4'd7 && ro_en)) $display("[TB] FAIL midrun_reach: got chal=%0d ro_en=%b expected 7 1", challenge, ro_en);
    else passed++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if ({ro_en, cnt_clr, busy} !== 3'b000)
      $display("[TB] FAIL midrun_async: got ro_en/cnt_clr/busy=%b expected 000", {ro_en, cnt_clr, busy});
    else passed++;
    checks++;
    if (resp !== 16'h0000 || tie_cnt !== 5'd0 || challenge !== 4'd0)
      $display("[TB] FAIL midrun_clear: got resp=%h tie=%0d chal=%0d expected 0000 0 0", resp, tie_cnt, challenge);
    else passed++;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (rv_count != rv_base) $display("[TB] FAIL midrun_no_valid: got %0d pulses expected 0", rv_count - rv_base);
    else passed++;
    do_start(2);
    wait_sweep("after_reset");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_ties();
    test_start_ignored();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
